wash_phase_timer: RTL and testbench

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

---
 rtl/wash_phase_timer.sv | 192 +++++++++++++++++++
 tb/tb_wash_phase_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: wash/spin phase timer with level-sensor debouncers.
//
// A four-state FSM (idle, cycle, spin, expired) times the wash phase
// (cycle_run) or the spin phase (spin_run). The timeout output rises exactly
// PRESCALE*TICKS clocks after the edge that samples the run request in idle.
// It holds while the originating run input stays high. Dropping that run
// input early aborts the phase without a timeout. Two free-running debouncers
// filter the tank level switches.
//
// Optional feature: define WASH_DOOR_PAUSE_EN to freeze the phase counters
// while door_close is low during cycle/spin. Without it door_close is unused.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   cycle_run       wash phase request (controller motor_on)
//   spin_run        spin phase request
//   door_close      door closed sensor
//   level_full_raw  raw tank-full switch
//   level_empty_raw raw tank-empty switch
//   cycle_timeout   registered, wash phase elapsed
//   spin_timeout    registered, spin phase elapsed
//   filled          registered, debounced level_full_raw
//   drained         registered, debounced level_empty_raw
//   busy            registered, high while in cycle or spin
module wash_phase_timer #(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned CYCLE_TICKS = 3,
  parameter int unsigned SPIN_TICKS  = 2,
  parameter int unsigned DEBOUNCE    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic cycle_run,
  input  logic spin_run,
  input  logic door_close,
  input  logic level_full_raw,
  input  logic level_empty_raw,
  output logic cycle_timeout,
  output logic spin_timeout,
  output logic filled,
  output logic drained,
  output logic busy
);

  localparam int unsigned MaxTicks = (CYCLE_TICKS > SPIN_TICKS) ? CYCLE_TICKS : SPIN_TICKS;
  localparam int unsigned PreW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned DbW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PreW-1:0]  PreLast   = PreW'(PRESCALE - 1);
  localparam logic [TickW-1:0] CycleLast = TickW'(CYCLE_TICKS - 1);
  localparam logic [TickW-1:0] SpinLast  = TickW'(SPIN_TICKS - 1);
  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StIdle, StCycle, StSpin, StExpired} state_e;

  state_e           state_q, state_d;
  logic             from_spin_q, from_spin_d;  // origin of the active/expired phase
  logic [PreW-1:0]  pre_q, pre_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             cto_q, cto_d;
  logic             sto_q, sto_d;
  logic             busy_q, busy_d;

  logic             run_sel;
  logic [TickW-1:0] tick_last;
  logic             advance;

`ifdef WASH_DOOR_PAUSE_EN
  assign advance = door_close;
`else
  logic unused_door_close;
  assign unused_door_close = door_close;
  assign advance           = 1'b1;
`endif

  // Only the input that started the phase matters; the other is ignored.
  assign run_sel   = from_spin_q ? spin_run : cycle_run;
  assign tick_last = from_spin_q ? SpinLast : CycleLast;

  always_comb begin
    state_d     = state_q;
    from_spin_d = from_spin_q;
    pre_d       = pre_q;
    tick_d      = tick_q;
    unique case (state_q)
      StIdle: begin
        pre_d  = '0;
        tick_d = '0;
        if (cycle_run) begin
          state_d     = StCycle;
          from_spin_d = 1'b0;
        end else if (spin_run) begin
          state_d     = StSpin;
          from_spin_d = 1'b1;
        end
      end
      StCycle, StSpin: begin
        if (!run_sel) begin
          state_d = StIdle;
          pre_d   = '0;
          tick_d  = '0;
        end else if (advance) begin
          if (pre_q == PreLast) begin
            pre_d = '0;
            if (tick_q == tick_last) begin
              // Terminal count: clear instead of running past it.
              state_d = StExpired;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + TickW'(1);
            end
          end else begin
            pre_d = pre_q + PreW'(1);
          end
        end
      end
      StExpired: begin
        if (!run_sel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StCycle) || (state_d == StSpin);
    cto_d  = (state_d == StExpired) && !from_spin_d;
    sto_d  = (state_d == StExpired) && from_spin_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      from_spin_q <= 1'b0;
      pre_q       <= '0;
      tick_q      <= '0;
      cto_q       <= 1'b0;
      sto_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      from_spin_q <= from_spin_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      cto_q       <= cto_d;
      sto_q       <= sto_d;
      busy_q      <= busy_d;
    end
  end

  // Debouncers: index 0 = full switch, index 1 = empty switch.
  logic [1:0]     db_raw;
  logic [1:0]     db_q, db_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  assign db_raw = {level_empty_raw, level_full_raw};

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (db_raw[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = db_raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q        <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign cycle_timeout = cto_q;
  assign spin_timeout  = sto_q;
  assign busy          = busy_q;
  assign filled        = db_q[0];
  assign drained       = db_q[1];

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer with default parameters.
module tb_wash_phase_timer;

`ifdef WASH_DOOR_PAUSE_EN
  localparam int Pause = 5;
`else
  localparam int Pause = 0;
`endif
  localparam int TRise = 12 + Pause;  // edge where cycle_timeout rises
  localparam int TFall = TRise + 3;   // edge that samples cycle_run low
  localparam int NVec  = TFall + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cycle_run = 1'b0, spin_run = 1'b0, door_close = 1'b1;
  logic level_full_raw = 1'b0, level_empty_raw = 1'b0;
  logic cycle_timeout, spin_timeout, filled, drained, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic cyc, spn, door, full, empty;
    logic e_cto, e_sto, e_filled, e_drained, e_busy;
  } vec_t;

  vec_t vecs [NVec];
  int   full_pat [6] = '{1, 1, 0, 1, 1, 1};

  wash_phase_timer dut (
    .clk             (clk),
    .reset           (reset),
    .cycle_run       (cycle_run),
    .spin_run        (spin_run),
    .door_close      (door_close),
    .level_full_raw  (level_full_raw),
    .level_empty_raw (level_empty_raw),
    .cycle_timeout   (cycle_timeout),
    .spin_timeout    (spin_timeout),
    .filled          (filled),
    .drained         (drained),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: cycle phase with a door-low window, debounce pattern and glitch.
    for (int k = 0; k < NVec; k++) begin
      vecs[k].cyc       = (k < TFall);
      vecs[k].spn       = 1'b0;
      vecs[k].door      = !(k >= 4 && k <= 8);
      vecs[k].full      = (k < 6) ? (full_pat[k] != 0) : (k != 6);
      vecs[k].empty     = (k >= 10);
      vecs[k].e_cto     = (k >= TRise) && (k < TFall);
      vecs[k].e_sto     = 1'b0;
      vecs[k].e_filled  = (k >= 5);
      vecs[k].e_drained = (k >= 12);
      vecs[k].e_busy    = (k < TRise);
    end

    #12;
    chk("reset cto", cycle_timeout, 1'b0);
    chk("reset sto", spin_timeout, 1'b0);
    chk("reset filled", filled, 1'b0);
    chk("reset drained", drained, 1'b0);
    chk("reset busy", busy, 1'b0);
    reset = 1'b1;
    step();

    for (int k = 0; k < NVec; k++) begin
      cycle_run       = vecs[k].cyc;
      spin_run        = vecs[k].spn;
      door_close      = vecs[k].door;
      level_full_raw  = vecs[k].full;
      level_empty_raw = vecs[k].empty;
      step();
      chk($sformatf("vec%0d cto", k), cycle_timeout, vecs[k].e_cto);
      chk($sformatf("vec%0d sto", k), spin_timeout, vecs[k].e_sto);
      chk($sformatf("vec%0d filled", k), filled, vecs[k].e_filled);
      chk($sformatf("vec%0d drained", k), drained, vecs[k].e_drained);
      chk($sformatf("vec%0d busy", k), busy, vecs[k].e_busy);
    end
    door_close = 1'b1;

    // Spin abort before the first timeout, then a full spin phase.
    spin_run = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("spin_abort e%0d busy", e), busy, 1'b1);
      chk($sformatf("spin_abort e%0d sto", e), spin_timeout, 1'b0);
    end
    spin_run = 1'b0;
    step();
    chk("spin_abort idle busy", busy, 1'b0);
    chk("spin_abort idle sto", spin_timeout, 1'b0);
    spin_run = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      chk($sformatf("spin e%0d sto", e), spin_timeout, (e == 8));
      chk($sformatf("spin e%0d busy", e), busy, (e < 8));
      chk($sformatf("spin e%0d cto", e), cycle_timeout, 1'b0);
    end
    spin_run = 1'b0;
    step();
    chk("spin release sto", spin_timeout, 1'b0);

    // Both requests together: cycle wins, spin never times out.
    cycle_run = 1'b1;
    spin_run  = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      step();
      chk($sformatf("both e%0d cto", e), cycle_timeout, (e == 12));
      chk($sformatf("both e%0d sto", e), spin_timeout, 1'b0);
      chk($sformatf("both e%0d busy", e), busy, (e < 12));
    end
    cycle_run = 1'b0;
    spin_run  = 1'b0;
    step();
    chk("both release cto", cycle_timeout, 1'b0);
    chk("both release sto", spin_timeout, 1'b0);

    // Reset mid-count: outputs clear at once, timing restarts after release.
    cycle_run = 1'b1;
    for (int e = 0; e <= 6; e++) step();
    chk("pre_reset filled", filled, 1'b1);
    chk("pre_reset busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async reset cto", cycle_timeout, 1'b0);
    chk("async reset sto", spin_timeout, 1'b0);
    chk("async reset filled", filled, 1'b0);
    chk("async reset drained", drained, 1'b0);
    chk("async reset busy", busy, 1'b0);
    #2;
    reset = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      step();
      chk($sformatf("restart e%0d cto", e), cycle_timeout, (e == 12));
      chk($sformatf("restart e%0d busy", e), busy, (e < 12));
      if (e == 2) chk("restart filled", filled, 1'b1);
    end
    cycle_run = 1'b0;
    step();
    chk("restart release cto", cycle_timeout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
